// File: rtl/ad_ip_jesd204_tpl_dac_sync_seq.sv
// Start/sync sequencer for the JESD204 TPL DAC datapath (link_clk domain).
// Define AD_TPL_DAC_SYNC_TIMEOUT_EN to enable the armed-state timeout.
module ad_ip_jesd204_tpl_dac_sync_seq #(
  parameter int DELAY_WIDTH   = 8,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                     link_clk,
  input  logic                     link_resetn,
  input  logic                     arm,
  input  logic                     disarm,
  input  logic                     ext_sync_ctl,
  input  logic                     dac_external_sync,
  input  logic                     link_ready,
  input  logic [DELAY_WIDTH-1:0]   delay_cfg,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_cfg,
  input  logic                     status_clr,
  output logic                     datapath_enable,
  output logic                     dds_sync,
  output logic                     armed,
  output logic                     link_lost,
  output logic                     timeout_err,
  output logic [COUNT_WIDTH-1:0]   sync_count
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_READY = 3'd1,
    ARMED      = 3'd2,
    ALIGN      = 3'd3,
    RUN        = 3'd4
  } state_t;

  localparam logic [DELAY_WIDTH-1:0] DELAY_ONE = 1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = 1;

  state_t                   state_q, state_d;
  logic                     ext_q;
  logic [DELAY_WIDTH-1:0]   delay_q;
  logic                     datapath_enable_q;
  logic                     dds_sync_q;
  logic                     armed_q;
  logic                     link_lost_q;
  logic [COUNT_WIDTH-1:0]   sync_count_q;
  logic                     ext_edge;
  logic                     tmo_expire;
  logic                     lost_set;
  logic                     tmo_set;

  assign ext_edge = dac_external_sync & ~ext_q;

  always_comb begin
    state_d  = state_q;
    lost_set = 1'b0;
    tmo_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm && !disarm) state_d = WAIT_READY;
      end
      WAIT_READY: begin
        if (disarm)          state_d = IDLE;
        else if (arm)        state_d = WAIT_READY;
        else if (link_ready) state_d = ext_sync_ctl ? ARMED : ALIGN;
      end
      ARMED: begin
        // A sync edge coinciding with timeout expiry still proceeds to ALIGN.
        if (disarm)                   state_d = IDLE;
        else if (!link_ready || arm)  state_d = WAIT_READY;
        else if (ext_edge)            state_d = ALIGN;
        else if (tmo_expire) begin
          state_d = IDLE;
          tmo_set = 1'b1;
        end
      end
      ALIGN: begin
        if (disarm)                   state_d = IDLE;
        else if (!link_ready || arm)  state_d = WAIT_READY;
        else if (delay_q == delay_cfg) state_d = RUN;
      end
      RUN: begin
        if (disarm) state_d = IDLE;
        else if (!link_ready) begin
          state_d  = IDLE;
          lost_set = 1'b1;
        end else if (arm) state_d = WAIT_READY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge link_clk or negedge link_resetn) begin
    if (!link_resetn) begin
      state_q           <= IDLE;
      ext_q             <= 1'b0;
      delay_q           <= '0;
      datapath_enable_q <= 1'b0;
      dds_sync_q        <= 1'b0;
      armed_q           <= 1'b0;
      link_lost_q       <= 1'b0;
      sync_count_q      <= '0;
    end else begin
      state_q           <= state_d;
      ext_q             <= dac_external_sync;
      delay_q           <= (state_q == ALIGN && state_d == ALIGN) ? delay_q + DELAY_ONE : '0;
      datapath_enable_q <= (state_d == RUN);
      dds_sync_q        <= (state_d == RUN) && (state_q != RUN);
      armed_q           <= (state_d == WAIT_READY) || (state_d == ARMED);
      link_lost_q       <= lost_set | (link_lost_q & ~status_clr);
      if (state_d == RUN && state_q != RUN) sync_count_q <= sync_count_q + COUNT_ONE;
    end
  end

`ifdef AD_TPL_DAC_SYNC_TIMEOUT_EN
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_ONE = 1;
  logic [TIMEOUT_WIDTH-1:0] tmo_q;
  logic                     timeout_err_q;

  // tmo_q counts completed ARMED cycles, so expiry leaves exactly timeout_cfg ARMED cycles.
  assign tmo_expire = (timeout_cfg != '0) && ((tmo_q + TMO_ONE) == timeout_cfg);

  always_ff @(posedge link_clk or negedge link_resetn) begin
    if (!link_resetn) begin
      tmo_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_q         <= (state_q == ARMED && state_d == ARMED) ? tmo_q + TMO_ONE : '0;
      timeout_err_q <= tmo_set | (timeout_err_q & ~status_clr);
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^{timeout_cfg, tmo_set};
  assign tmo_expire     = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  assign datapath_enable = datapath_enable_q;
  assign dds_sync        = dds_sync_q;
  assign armed           = armed_q;
  assign link_lost       = link_lost_q;
  assign sync_count      = sync_count_q;

endmodule
